// File: rtl/uart_pkg.sv
// Shared UART package.
// Holds the byte width used throughout the UART and the default sizing
// of the receive/transmit buffers so every block agrees on them.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_FIFO_DEPTH_BITS = 4;
  localparam int UART_TIMEOUT_BITS    = 16;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: 2^ADDR_BITS x DATA_BITS register array for UART buffers.
// Synchronous write, asynchronous read, no reset on the storage.
//
// Ports:
//   i_clk    system clock
//   i_we     write enable, i_wdata stored at i_waddr on the rising edge
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  contents at i_raddr (combinational)
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int ADDR_BITS = UART_FIFO_DEPTH_BITS,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);

  logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind the UART
// receiver, with level, threshold, sticky overrun and idle-timeout status.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rxData            byte from the receiver
//   rxDataAvailable   one-cycle strobe qualifying rxData
//   readEnable        pop request (ignored while empty)
//   flush             discard all stored bytes
//   clearOverrun      clear the sticky overrun flag
//   threshold         level at which thresholdReached asserts (0 = off)
//   timeoutCycles     idle cycles before timeout (0 = off)
//   dataOut           byte at the head, valid while dataValid
//   dataValid         FIFO not empty
//   level             stored byte count, 0..2^DEPTH_BITS
//   full              level == 2^DEPTH_BITS
//   thresholdReached  level >= threshold, threshold != 0
//   overrun           sticky, a byte was dropped
//   timeout           sticky, bytes waiting and the line idle
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_BITS   = UART_FIFO_DEPTH_BITS,
  parameter int TIMEOUT_BITS = UART_TIMEOUT_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] rxData,
  input  logic                      rxDataAvailable,
  input  logic                      readEnable,
  input  logic                      flush,
  input  logic                      clearOverrun,
  input  logic [DEPTH_BITS:0]       threshold,
  input  logic [TIMEOUT_BITS-1:0]   timeoutCycles,
  output logic [UART_DATA_BITS-1:0] dataOut,
  output logic                      dataValid,
  output logic [DEPTH_BITS:0]       level,
  output logic                      full,
  output logic                      thresholdReached,
  output logic                      overrun,
  output logic                      timeout
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_BITS:0]     r_wptr;
  logic [DEPTH_BITS:0]     r_rptr;
  logic                    r_overrun;
  logic                    r_timeout;
  logic [TIMEOUT_BITS-1:0] r_tcnt;

  logic [DEPTH_BITS:0]     w_level;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_we;
  logic                    w_activity;
  logic [TIMEOUT_BITS:0]   w_cnt_next;
  logic                    w_to_hit;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH_BITS] != r_rptr[DEPTH_BITS]) &&
                   (r_wptr[DEPTH_BITS-1:0] == r_rptr[DEPTH_BITS-1:0]);

  // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
  assign w_pop  = readEnable & ~w_empty;
  assign w_push = rxDataAvailable & (~w_full | w_pop);
  // A byte swallowed by flush is discarded silently, not counted as overrun.
  assign w_drop = rxDataAvailable & w_full & ~w_pop & ~flush;
  assign w_we   = w_push & ~flush;

  assign w_activity = w_push | w_pop | flush;

  // Compare counter+1 one bit wider so a saturated counter never wraps to a match.
  assign w_cnt_next = {1'b0, r_tcnt} + {{TIMEOUT_BITS{1'b0}}, 1'b1};
  assign w_to_hit   = (timeoutCycles != '0) && (w_cnt_next == {1'b0, timeoutCycles});

  uart_fifo_mem #(
    .ADDR_BITS (DEPTH_BITS),
    .DATA_BITS (UART_DATA_BITS)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr[DEPTH_BITS-1:0]),
    .i_wdata (rxData),
    .i_raddr (r_rptr[DEPTH_BITS-1:0]),
    .o_rdata (dataOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      // Collapse onto the read pointer; stored bytes become unreachable.
      r_wptr <= r_rptr;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Set wins over a same-cycle clear so a drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clearOverrun) begin
      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_activity || w_empty) begin
        r_tcnt <= '0;
      end else if (r_tcnt != {TIMEOUT_BITS{1'b1}}) begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      if (w_activity) begin
        r_timeout <= 1'b0;
      end else if (!w_empty && w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign dataValid        = ~w_empty;
  assign level            = w_level;
  assign full             = w_full;
  assign thresholdReached = (threshold != '0) && (w_level >= threshold);
  assign overrun          = r_overrun;
  assign timeout          = r_timeout;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rxData;
  logic        rxDataAvailable;
  logic        readEnable;
  logic        flush;
  logic        clearOverrun;
  logic [4:0]  threshold;
  logic [15:0] timeoutCycles;
  logic [7:0]  dataOut;
  logic        dataValid;
  logic [4:0]  level;
  logic        full;
  logic        thresholdReached;
  logic        overrun;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_ov;
  bit         m_to;
  int         m_idle;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rxData           (rxData),
    .rxDataAvailable  (rxDataAvailable),
    .readEnable       (readEnable),
    .flush            (flush),
    .clearOverrun     (clearOverrun),
    .threshold        (threshold),
    .timeoutCycles    (timeoutCycles),
    .dataOut          (dataOut),
    .dataValid        (dataValid),
    .level            (level),
    .full             (full),
    .thresholdReached (thresholdReached),
    .overrun          (overrun),
    .timeout          (timeout)
  );

  typedef struct {
    logic       av;
    logic [7:0] d;
    logic       rd;
    logic       fl;
    logic       clr;
    logic [4:0] lvl;
    logic       vld;
    logic [7:0] dout;
    logic       ov;
    logic       thr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ov   = 0;
    m_to   = 0;
    m_idle = 0;
  endfunction

  // Behavioural rules: a queue of bytes, a sticky drop flag and a count of
  // idle cycles since the last push/pop/flush while bytes are waiting.
  function automatic void model_step(input logic av, input logic [7:0] d,
                                     input logic rd, input logic fl, input logic clr);
    bit pop_ok, push_ok, drop;
    pop_ok = rd && (m_q.size() > 0);
    drop   = 0;
    if (fl) begin
      m_q.delete();
      m_to   = 0;
      m_idle = 0;
    end else begin
      push_ok = av && ((m_q.size() < 16) || pop_ok);
      drop    = av && !push_ok;
      if (pop_ok)  void'(m_q.pop_front());
      if (push_ok) m_q.push_back(d);
      if (push_ok || pop_ok) begin
        m_to   = 0;
        m_idle = 0;
      end else if (m_q.size() == 0) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (timeoutCycles != 0 && m_idle == int'(timeoutCycles)) m_to = 1;
      end
    end
    if (drop) m_ov = 1;
    else if (clr) m_ov = 0;
  endfunction

  task automatic check_model(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, ".level"}, 32'(level), 32'(sz));
    chk({tag, ".dataValid"}, 32'(dataValid), 32'(sz != 0));
    if (sz != 0) chk({tag, ".dataOut"}, 32'(dataOut), 32'(m_q[0]));
    chk({tag, ".full"}, 32'(full), 32'(sz == 16));
    chk({tag, ".thresholdReached"}, 32'(thresholdReached),
        32'((threshold != 0) && (sz >= int'(threshold))));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // One clock: drive at negedge, model advances at posedge, sample 1 ns later.
  task automatic step(input logic av, input logic [7:0] d, input logic rd,
                      input logic fl, input logic clr, input string tag);
    @(negedge clk);
    rxDataAvailable = av;
    rxData          = d;
    readEnable      = rd;
    flush           = fl;
    clearOverrun    = clr;
    @(posedge clk);
    model_step(av, d, rd, fl, clr);
    #1;
    rxDataAvailable = 1'b0;
    readEnable      = 1'b0;
    flush           = 1'b0;
    clearOverrun    = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    int mode;

    rst_n = 1'b0;
    rxData = '0; rxDataAvailable = 0; readEnable = 0; flush = 0; clearOverrun = 0;
    threshold = 5'd2; timeoutCycles = 16'd0;
    model_reset();
    do_reset();
    #1;
    chk("reset.level", 32'(level), 0);
    chk("reset.dataValid", 32'(dataValid), 0);
    chk("reset.full", 32'(full), 0);
    chk("reset.overrun", 32'(overrun), 0);
    chk("reset.timeout", 32'(timeout), 0);
    chk("reset.thr", 32'(thresholdReached), 0);

    // Directed table, threshold = 2, timeout disabled
    //           av  d      rd fl clr  lvl vld dout   ov thr
    tbl[0]  = '{1, 8'h41, 0, 0, 0,  1, 1, 8'h41, 0, 0};
    tbl[1]  = '{0, 8'h00, 0, 0, 0,  1, 1, 8'h41, 0, 0};
    tbl[2]  = '{1, 8'h42, 0, 0, 0,  2, 1, 8'h41, 0, 1};
    tbl[3]  = '{0, 8'h00, 0, 0, 1,  2, 1, 8'h41, 0, 1};
    tbl[4]  = '{1, 8'h43, 0, 0, 0,  3, 1, 8'h41, 0, 1};
    tbl[5]  = '{0, 8'h00, 1, 0, 0,  2, 1, 8'h42, 0, 1};
    tbl[6]  = '{0, 8'h00, 1, 0, 0,  1, 1, 8'h43, 0, 0};
    tbl[7]  = '{0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0, 0};
    tbl[8]  = '{0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0, 0};
    tbl[9]  = '{1, 8'h55, 1, 0, 0,  1, 1, 8'h55, 0, 0};
    tbl[10] = '{0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0, 0};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].av, tbl[i].d, tbl[i].rd, tbl[i].fl, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.lvl", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d.vld", i), 32'(dataValid), 32'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("tbl%0d.dout", i), 32'(dataOut), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d.ov", i), 32'(overrun), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d.thr", i), 32'(thresholdReached), 32'(tbl[i].thr));
    end

    // Overflow: 17 pushes, the last is dropped
    threshold = 5'd0;
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, "fill");
    chk("ovf.full", 32'(full), 1);
    chk("ovf.level16", 32'(level), 16);
    chk("ovf.ov_before", 32'(overrun), 0);
    step(1, 8'h10, 0, 0, 0, "ovf.drop");
    chk("ovf.ov_set", 32'(overrun), 1);
    chk("ovf.head", 32'(dataOut), 0);
    step(1, 8'h77, 0, 0, 1, "ovf.setclr");
    chk("ovf.set_wins", 32'(overrun), 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf.order", 32'(dataOut), 32'(i));
      step(0, 0, 1, 0, 0, "ovf.drain");
    end
    chk("ovf.empty", 32'(dataValid), 0);
    step(0, 0, 0, 0, 1, "ovf.clr");
    chk("ovf.cleared", 32'(overrun), 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, "fp.fill");
    step(1, 8'hAA, 1, 0, 0, "fp.pushpop");
    chk("fp.level", 32'(level), 16);
    chk("fp.ov", 32'(overrun), 0);
    chk("fp.head", 32'(dataOut), 32'h21);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fp.last", 32'(dataOut), 32'hAA);
      step(0, 0, 1, 0, 0, "fp.drain");
    end

    // Threshold
    threshold = 5'd4;
    for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0, 0, "thr.push");
    chk("thr.below", 32'(thresholdReached), 0);
    step(1, 8'h03, 0, 0, 0, "thr.push4");
    chk("thr.at4", 32'(thresholdReached), 1);
    step(0, 0, 1, 0, 0, "thr.pop");
    chk("thr.after_pop", 32'(thresholdReached), 0);
    step(0, 0, 0, 1, 0, "thr.flush");
    threshold = 5'd0;
    for (int i = 0; i < 4; i++) step(1, 8'(i), 0, 0, 0, "thr0.push");
    chk("thr0.never", 32'(thresholdReached), 0);
    threshold = 5'd20;
    for (int i = 0; i < 12; i++) step(1, 8'(i), 0, 0, 0, "thr20.push");
    chk("thr20.never", 32'(thresholdReached), 0);
    threshold = 5'd16;
    #1;
    chk("thr16.full", 32'(thresholdReached), 1);
    step(0, 0, 0, 1, 0, "thr.flush2");
    threshold = 5'd0;

    // Idle timeout
    timeoutCycles = 16'd10;
    step(1, 8'h5A, 0, 0, 0, "to.push");
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0, 0, "to.idle");
      chk($sformatf("to.idle%0d", k), 32'(timeout), 32'(k == 10));
    end
    step(0, 0, 1, 0, 0, "to.pop");
    chk("to.cleared", 32'(timeout), 0);
    timeoutCycles = 16'd0;
    step(1, 8'h5B, 0, 0, 0, "to0.push");
    repeat (40) step(0, 0, 0, 0, 0, "to0.idle");
    chk("to0.never", 32'(timeout), 0);
    step(0, 0, 1, 0, 0, "to0.pop");

    // Flush keeps overrun, drops a concurrent push
    for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0, 0, "fl.fill");
    chk("fl.ov", 32'(overrun), 1);
    step(1, 8'h99, 0, 1, 0, "fl.flushpush");
    chk("fl.level", 32'(level), 0);
    chk("fl.valid", 32'(dataValid), 0);
    chk("fl.ov_kept", 32'(overrun), 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0, "fl.push5");
    step(1, 8'h66, 0, 1, 0, "fl.flushpush2");
    chk("fl.level2", 32'(level), 0);
    chk("fl.ov_kept2", 32'(overrun), 1);

    // Asynchronous reset between edges
    threshold = 5'd1;
    timeoutCycles = 16'd2;
    for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0, 0, "ar.push");
    step(0, 0, 0, 0, 0, "ar.idle");
    step(0, 0, 0, 0, 0, "ar.idle");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.level", 32'(level), 0);
    chk("ar.valid", 32'(dataValid), 0);
    chk("ar.full", 32'(full), 0);
    chk("ar.thr", 32'(thresholdReached), 0);
    chk("ar.ov", 32'(overrun), 0);
    chk("ar.to", 32'(timeout), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        threshold     = 5'($urandom_range(0, 20));
        timeoutCycles = 16'($urandom_range(0, 12));
      end
      mode = (n / 300) % 3;
      b = 8'($urandom);
      case (mode)
        0: step($urandom_range(0, 99) < 70, b, $urandom_range(0, 99) < 20,
                $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 5, "rnd");
        1: step($urandom_range(0, 99) < 20, b, $urandom_range(0, 99) < 50,
                $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 5, "rnd");
        default: step($urandom_range(0, 99) < 35, b, $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, "rnd");
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each byte the receiver reports with its one-cycle data-available strobe and holds it in a first-word-fall-through FIFO. The bus-facing peripheral logic reads bytes from it through a pop handshake. It also provides level, threshold, overrun and idle-timeout status for the UART interrupt logic.

Parameters:
DEPTH_BITS, 4, log2 of FIFO depth (depth = 2^DEPTH_BITS = 16)
TIMEOUT_BITS, 16, width of the idle-timeout counter and of timeoutCycles

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
rxData  input  8  byte from the UART receiver
rxDataAvailable  input  1  one-cycle strobe: rxData is valid this cycle
readEnable  input  1  pop request from the bus side
flush  input  1  discard all contents
clearOverrun  input  1  clear the sticky overrun flag
threshold  input  DEPTH_BITS+1  level at which thresholdReached asserts
timeoutCycles  input  TIMEOUT_BITS  idle cycles before timeout; 0 disables the timeout
dataOut  output  8  byte at the FIFO head
dataValid  output  1  FIFO not empty
level  output  DEPTH_BITS+1  number of stored bytes, 0..16
full  output  1  level == 16
thresholdReached  output  1  level >= threshold and threshold != 0
overrun  output  1  sticky: a byte was dropped
timeout  output  1  sticky: bytes are waiting and the line has been idle

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read/write pointers and level go to 0.
  - overrun = 0, timeout = 0, timeout counter = 0.
  - Memory contents are not reset.
  - dataOut is don't-care while dataValid = 0.
- Pointers are DEPTH_BITS+1 wide and wrap naturally.
  - empty = (pointers equal).
  - full = (MSBs differ, lower bits equal).
  - level = writePtr - readPtr, modulo 2^(DEPTH_BITS+1).
- Push: rxDataAvailable = 1 and not full.
  - rxData is written to mem[writePtr] and writePtr increments on the same clock edge.
  - The byte is visible on dataOut/dataValid the next cycle if the FIFO was empty (1-cycle latency).
- Pop: readEnable = 1 and dataValid = 1.
  - readPtr increments; the next head appears on dataOut the following cycle.
  - readEnable while empty is ignored and has no side effects.
- Full and rxDataAvailable, no pop: byte is dropped, overrun set to 1, contents unchanged.
- Full with push and pop in the same cycle: both succeed, level stays 16, no overrun.
- Empty with push and pop in the same cycle: pop is ignored, push succeeds, level becomes 1.
- overrun:
  - Set by a drop; cleared by clearOverrun.
  - A set and clear in the same cycle leaves overrun = 1.
  - flush does not clear overrun.
- flush:
  - Sets both pointers to readPtr's current value (level = 0) and clears timeout and the timeout counter.
  - It has priority over push and pop in the same cycle; the pushed byte is discarded and does not set overrun.
- thresholdReached is combinational from level and threshold.
  - It is 0 when threshold = 0.
  - Threshold values above 16 never assert.
- Timeout counter:
  - Cleared on any push, pop, flush, or while level = 0.
  - Otherwise increments by 1 per cycle, saturating at the all-ones value.
  - When timeoutCycles != 0 and (counter + 1) == timeoutCycles, timeout is set to 1 on that edge.
- timeout is sticky. It clears on the next push, pop or flush.
- Outputs change only on clk edges or on asynchronous reset; none are combinational from readEnable.

Decomposition:
- Shared UART package holds:
  - UART_DATA_BITS = 8.
  - The default FIFO DEPTH_BITS.
  - The default TIMEOUT_BITS.
- One sub-module, uart_fifo_mem: a 2^DEPTH_BITS x 8 register array with a synchronous write port and an asynchronous read port.
  - It is reused by the planned TX buffer.
  - Pointer, flag and timeout logic stay in uart_rx_fifo.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43 with gaps, no reads -> level = 3, dataValid = 1, dataOut = 0x41; pop 3 times -> 0x42, 0x43 on successive heads, then dataValid = 0, level = 0.
2. Push 17 bytes 0x00..0x10 with no reads -> full = 1 after 16; 17th dropped and overrun = 1; pop all -> 0x00..0x0F in order; clearOverrun -> overrun = 0.
3. Fill to 16, then push 0xAA while popping -> level stays 16, overrun = 0; drain -> 0xAA is last. Also empty FIFO with push 0x55 and pop in the same cycle -> level = 1, dataOut = 0x55.
4. threshold = 4, push 4 bytes -> thresholdReached asserts the cycle after the 4th push; pop 1 -> deasserts. threshold = 0 -> never asserts.
5. timeoutCycles = 10, push 1 byte then idle -> timeout = 1 exactly 10 cycles after the push; pop -> timeout = 0. timeoutCycles = 0 -> timeout never sets.
6. Push 5 bytes, assert flush together with a push -> level = 0, dataValid = 0, overrun unchanged. Then assert rst_n low mid-stream between clock edges -> all status outputs 0 immediately.
